// File: rtl/score_pkg.sv
// score_pkg: shared constants and helpers for the score display driver.
//   SEG_BLANK, SEG_0..SEG_9 : active-low seven-segment glyphs, bit order gfedcba
//   state_e                 : conversion sequencer states
//   nbcd(width)             : BCD digits needed to hold 2^width-1
//   max_dec(digits)         : largest value showable on 'digits' decimal digits
package score_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  // 2^w-1 is never a power of ten, so its digit count equals that of 2^w,
  // i.e. floor(w*log10(2))+1; 1233/4096 approximates log10(2) closely enough.
  function automatic int nbcd(input int width);
    return ((width * 32'sd1233) >>> 12) + 32'sd1;
  endfunction

  function automatic int max_dec(input int digits);
    int v;
    v = 32'sd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 32'sd10;
    end
    return v - 32'sd1;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// seg7_digit: one BCD digit to active-low seven-segment glyph.
//   bcd_i   : BCD value; codes 10..15 display blank
//   blank_i : force the digit blank
//   seg_o   : segments gfedcba, active-low
module seg7_digit
  import score_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Glyph lookup with blank override
  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// score_bcd_display: binary score to DIGITS seven-segment displays.
// A double-dabble sequencer converts the score in WIDTH+2 cycles; the result
// is held in disp_bcd and rendered with leading-zero blanking, 9..9
// saturation on overflow and an optional blink.
//   clk, reset : clock, synchronous active-high reset
//   score      : binary score, sampled only while idle
//   blink      : flash all digits every BLINK_CYCLES cycles
//   hex        : active-low segments, digit i at hex[7*i+6:7*i]
//   busy       : conversion in progress
//   done       : one-cycle pulse when the displayed value updates
//   ovf        : last converted score exceeded 10^DIGITS-1
module score_bcd_display
  import score_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 3,
  parameter int BLANK_LZ     = 1,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      score,
  input  logic                  blink,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int NBCD = nbcd(WIDTH);
  localparam int SRW  = WIDTH + 4 * NBCD;
  localparam int CNTW = $clog2(WIDTH);
  localparam int CMPW = (WIDTH > 32) ? WIDTH : 32;
  localparam int BCW  = $clog2(BLINK_CYCLES);
  localparam logic [CMPW-1:0] MAX_VAL = CMPW'(max_dec(DIGITS));
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [BCW-1:0]  BC_LAST  = BCW'(BLINK_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       last_q, last_d;
  logic [SRW-1:0]         sr_q, sr_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [4*DIGITS-1:0]    disp_q, disp_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic [BCW-1:0]         bcnt_q, bcnt_d;
  logic                   phase_off_q, phase_off_d;

  logic [SRW-1:0]         sr_adj_s;
  logic [4*DIGITS-1:0]    bcd_res_s;
  logic                   sat_s;
  logic [DIGITS-1:0]      blank_s;
  logic                   zero_above_s;

  // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift
  always_comb begin
    sr_adj_s = sr_q;
    for (int n = 0; n < NBCD; n++) begin
      if (sr_q[WIDTH+4*n +: 4] >= 4'd5) begin
        sr_adj_s[WIDTH+4*n +: 4] = sr_q[WIDTH+4*n +: 4] + 4'd3;
      end else begin
        sr_adj_s[WIDTH+4*n +: 4] = sr_q[WIDTH+4*n +: 4];
      end
    end
  end

  // Digits beyond what the score width can reach are always zero
  for (genvar g = 0; g < DIGITS; g++) begin : g_res
    if (g < NBCD) begin : g_have
      assign bcd_res_s[4*g +: 4] = sr_q[WIDTH+4*g +: 4];
    end else begin : g_zero
      assign bcd_res_s[4*g +: 4] = 4'd0;
    end
  end

  assign sat_s = (CMPW'(last_q) > MAX_VAL);

  // Conversion sequencer next-state
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (score != last_q) begin
          last_d  = score;
          sr_d    = {{(4*NBCD){1'b0}}, score};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        sr_d  = {sr_adj_s[SRW-2:0], 1'b0};
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = LOAD;
        end else begin
          state_d = CONV;
        end
      end
      LOAD: begin
        if (sat_s) begin
          disp_d = {DIGITS{4'd9}};
        end else begin
          disp_d = bcd_res_s;
        end
        ovf_d   = sat_s;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Blink phase: counter idles at 0 (phase on) while blink is low
  always_comb begin
    bcnt_d      = bcnt_q;
    phase_off_d = phase_off_q;
    if (blink) begin
      if (bcnt_q == BC_LAST) begin
        bcnt_d      = '0;
        phase_off_d = ~phase_off_q;
      end else begin
        bcnt_d      = bcnt_q + BCW'(1);
        phase_off_d = phase_off_q;
      end
    end else begin
      bcnt_d      = '0;
      phase_off_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      disp_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      bcnt_q      <= '0;
      phase_off_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      bcnt_q      <= bcnt_d;
      phase_off_q <= phase_off_d;
    end
  end

  // Per-digit blanking: blink-off phase, or a leading zero (never digit 0,
  // never while saturated)
  always_comb begin
    zero_above_s = 1'b1;
    blank_s      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (disp_q[4*i +: 4] == 4'd0);
      if (phase_off_q) begin
        blank_s[i] = 1'b1;
      end else if ((BLANK_LZ != 0) && (i > 0) && !ovf_q && zero_above_s) begin
        blank_s[i] = 1'b1;
      end else begin
        blank_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_digit u_dig (
      .bcd_i   (disp_q[4*g +: 4]),
      .blank_i (blank_s[g]),
      .seg_o   (hex[7*g +: 7])
    );
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule
